ber_sync_counter: RTL and testbench

Bit-error-rate measurement block for the PRBS9 + BPSK + RC link. It decimates the oversampled RX decision stream at a selectable phase and compares it against a delayed copy of the TX reference bits. It automatically searches for the channel delay, then counts bits and errors while locked, and declares loss of lock when errors exceed a threshold. It sits after the RC filter / RX slicer and drives the BER status LED and readout counters.

---
 rtl/ber_sync_counter.sv | 162 ++++++++++++++++
 tb/tb_ber_sync_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_sync_counter.sv
// rtl/ber_sync_counter.sv - BER counter with automatic channel-delay search, lock and loss-of-lock tracking
// Optional feature: define BER_POLARITY_AUTO_EN to also lock onto a fully inverted channel.
module ber_sync_counter #(
    parameter int OS       = 4,
    parameter int MAX_DLY  = 16,
    parameter int WINDOW   = 511,
    parameter int LOSS_THR = 127,
    parameter int CNT_W    = 64
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_clear,
    input  logic                       i_ref_bit,
    input  logic                       i_rx_bit,
    input  logic [$clog2(OS)-1:0]      i_phase,
    output logic                       o_locked,
    output logic [$clog2(MAX_DLY)-1:0] o_latency,
    output logic [CNT_W-1:0]           o_bit_count,
    output logic [CNT_W-1:0]           o_err_count,
    output logic                       o_is_zero
);
    localparam int PW = $clog2(OS);
    localparam int LW = $clog2(MAX_DLY);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(WINDOW + 1);
    localparam logic [PW-1:0]    CNT_LAST = PW'(OS - 1);
    localparam logic [LW-1:0]    LAT_LAST = LW'(MAX_DLY - 1);
    localparam logic [WW-1:0]    WIN_LAST = WW'(WINDOW - 1);
    localparam logic [EW-1:0]    ERR_THR  = EW'(LOSS_THR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef BER_POLARITY_AUTO_EN
    localparam logic [EW-1:0]    ERR_ALL  = EW'(WINDOW);
`endif

    typedef enum logic {ST_SEARCH, ST_LOCK} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_cnt;
    logic [PW-1:0]      r_phase_prev;
    logic [MAX_DLY-1:0] r_ref_line;
    logic [WW-1:0]      r_wcnt;
    logic [EW-1:0]      r_werr;
    logic [LW-1:0]      r_latency;
    logic [CNT_W-1:0]   r_bit_count;
    logic [CNT_W-1:0]   r_err_count;

    logic [PW-1:0]      w_phase;
    logic               w_phase_chg;
    logic               w_decide;
    logic               w_win_end;
    logic               w_inv;
    logic               w_err;
    logic [EW-1:0]      w_werr_sum;

    assign w_phase     = (i_phase > CNT_LAST) ? CNT_LAST : i_phase;
    assign w_phase_chg = (i_phase != r_phase_prev);
    // A phase change restarts the window, so the decision in that cycle is discarded.
    assign w_decide    = (r_cnt == w_phase) && !w_phase_chg;
    assign w_win_end   = (r_wcnt == WIN_LAST);

`ifdef BER_POLARITY_AUTO_EN
    logic r_invert;
    assign w_inv = r_invert;
`else
    assign w_inv = 1'b0;
`endif

    assign w_err      = i_rx_bit ^ r_ref_line[r_latency] ^ w_inv;
    assign w_werr_sum = r_werr + EW'(w_err);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state      <= ST_SEARCH;
            r_cnt        <= '0;
            r_phase_prev <= i_phase;
            r_ref_line   <= '0;
            r_wcnt       <= '0;
            r_werr       <= '0;
            r_latency    <= '0;
            r_bit_count  <= '0;
            r_err_count  <= '0;
`ifdef BER_POLARITY_AUTO_EN
            r_invert     <= 1'b0;
`endif
        end else if (i_enable) begin
            r_cnt        <= (r_cnt == CNT_LAST) ? '0 : r_cnt + PW'(1);
            r_phase_prev <= i_phase;
            if (r_cnt == '0) begin
                r_ref_line <= {r_ref_line[MAX_DLY-2:0], i_ref_bit};
            end

            if (w_phase_chg) begin
                r_state   <= ST_SEARCH;
                r_latency <= '0;
                r_wcnt    <= '0;
                r_werr    <= '0;
`ifdef BER_POLARITY_AUTO_EN
                r_invert  <= 1'b0;
`endif
            end else if (w_decide) begin
                if (w_win_end) begin
                    r_wcnt <= '0;
                    r_werr <= '0;
                    case (r_state)
                        ST_SEARCH: begin
                            if (w_werr_sum == '0) begin
                                r_state     <= ST_LOCK;
                                r_bit_count <= '0;
                                r_err_count <= '0;
                            end
`ifdef BER_POLARITY_AUTO_EN
                            else if (w_werr_sum == ERR_ALL) begin
                                r_state     <= ST_LOCK;
                                r_bit_count <= '0;
                                r_err_count <= '0;
                                r_invert    <= 1'b1;
                            end
`endif
                            else begin
                                r_latency <= (r_latency == LAT_LAST) ? '0 : r_latency + LW'(1);
                            end
                        end
                        ST_LOCK: begin
                            if (w_werr_sum > ERR_THR) begin
                                r_state   <= ST_SEARCH;
                                r_latency <= '0;
`ifdef BER_POLARITY_AUTO_EN
                                r_invert  <= 1'b0;
`endif
                            end
                        end
                        default: r_state <= ST_SEARCH;
                    endcase
                end else begin
                    r_wcnt <= r_wcnt + WW'(1);
                    r_werr <= w_werr_sum;
                end
            end

            // Clear beats a same-cycle decision; counters saturate instead of wrapping.
            if (i_clear) begin
                r_bit_count <= '0;
                r_err_count <= '0;
            end else if (w_decide && (r_state == ST_LOCK)) begin
                if (r_bit_count != CNT_MAX) begin
                    r_bit_count <= r_bit_count + CNT_W'(1);
                end
                if (w_err && (r_err_count != CNT_MAX)) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_locked    = (r_state == ST_LOCK);
    assign o_latency   = r_latency;
    assign o_bit_count = r_bit_count;
    assign o_err_count = r_err_count;
    assign o_is_zero   = o_locked && (r_err_count == '0) && (r_bit_count != '0);

endmodule

// File: tb/tb_ber_sync_counter.sv
// tb/tb_ber_sync_counter.sv - randomized self-checking bench for ber_sync_counter
module tb_ber_sync_counter;
    localparam int OS       = 4;
    localparam int MAX_DLY  = 16;
    localparam int WINDOW   = 511;
    localparam int LOSS_THR = 127;
    localparam int CNT_W    = 10;
    localparam int PW       = $clog2(OS);
    localparam int LW       = $clog2(MAX_DLY);
    localparam int NREF     = 32768;
    localparam longint SATV = (longint'(1) << CNT_W) - 1;
    localparam int LIMIT    = 60000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             i_reset, i_enable, i_clear, i_ref_bit, i_rx_bit;
    logic [PW-1:0]    i_phase;
    logic             o_locked, o_is_zero;
    logic [LW-1:0]    o_latency;
    logic [CNT_W-1:0] o_bit_count, o_err_count;

    ber_sync_counter #(.OS(OS), .MAX_DLY(MAX_DLY), .WINDOW(WINDOW), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
        .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit), .i_phase(i_phase),
        .o_locked(o_locked), .o_latency(o_latency), .o_bit_count(o_bit_count),
        .o_err_count(o_err_count), .o_is_zero(o_is_zero)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit     refs [NREF];
    int     tcnt, baud, ndec, dly, lock_at, loss_at;
    int     fb0, fb1, fb2;
    bit     inv, lock_pol, m_locked, m_pol;
    logic [PW-1:0] prev_phase;
    longint m_bits, m_errs;

    function automatic longint sat(input longint x);
        return (x > SATV) ? SATV : x;
    endfunction

    // One clock: drive the stimulus implied by the channel model, then advance the model.
    task automatic step();
        bit e, dec, pchg;
        int eff;
        e = (baud == fb0) || (baud == fb1) || (baud == fb2);
        i_ref_bit = refs[baud % NREF];
        i_rx_bit  = refs[(baud - dly) % NREF] ^ inv ^ e;
        if (!i_enable) i_rx_bit = 1'($urandom_range(1, 0));
        eff  = (int'(i_phase) >= OS) ? OS - 1 : int'(i_phase);
        pchg = i_enable && !i_reset && (i_phase != prev_phase);
        dec  = i_enable && !i_reset && !pchg && (tcnt == eff);
        @(posedge clock);
        #1;
        if (i_reset) begin
            tcnt = 0; baud++; ndec = 0; m_locked = 0; m_pol = 0;
            m_bits = 0; m_errs = 0; lock_at = -1; loss_at = -1; prev_phase = i_phase;
        end else if (i_enable) begin
            if (pchg) begin
                ndec = 0; m_locked = 0; m_pol = 0; lock_at = -1; loss_at = -1;
            end else if (dec) begin
                ndec++;
                if (ndec == lock_at) begin
                    m_locked = 1; m_pol = lock_pol; m_bits = 0; m_errs = 0;
                end else if (m_locked) begin
                    m_bits = sat(m_bits + 1);
                    m_errs = sat(m_errs + longint'(e ^ inv ^ m_pol));
                end
                if (ndec == loss_at) m_locked = 0;
            end
            if (i_clear) begin m_bits = 0; m_errs = 0; end
            prev_phase = i_phase;
            tcnt++;
            if (tcnt == OS) begin tcnt = 0; baud++; end
        end
        i_clear = 1'b0;
    endtask

    task automatic run_dec(input int target);
        for (int i = 0; i < LIMIT && ndec < target; i++) step();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_enable = 1'b1; i_clear = 1'b1; i_phase = PW'(2); dly = 5; inv = 0;
        do_reset();
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", o_locked); end
        n_cmp++; if (o_latency !== '0) begin n_err++; $display("FAIL reset_latency: got %0d want 0", o_latency); end
        n_cmp++; if (o_bit_count !== '0 || o_err_count !== '0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count); end
        n_cmp++; if (o_is_zero !== 1'b0) begin n_err++; $display("FAIL reset_is_zero: got %b want 0", o_is_zero); end
    endtask

    task automatic test_lock();
        lock_pol = 0;
        lock_at  = (5 + 1) * WINDOW;
        run_dec(lock_at - 1);
        n_cmp++; if (ndec != lock_at - 1) begin n_err++; $display("FAIL lock_timeout: got %0d decisions want %0d", ndec, lock_at - 1); end
        n_cmp++; if (o_locked !== 1'b0 || o_latency !== LW'(5)) begin n_err++; $display("FAIL lock_early: got locked=%b lat=%0d want 0/5", o_locked, o_latency); end
        run_dec(lock_at);
        n_cmp++; if (o_locked !== 1'b1 || o_latency !== LW'(5)) begin n_err++; $display("FAIL lock_rise: got locked=%b lat=%0d want 1/5", o_locked, o_latency); end
        n_cmp++; if (o_bit_count !== '0 || o_err_count !== '0) begin n_err++; $display("FAIL lock_counts_start: got %0d/%0d want 0/0", o_bit_count, o_err_count); end
        run_cycles(200);
        n_cmp++; if (o_bit_count !== CNT_W'(50) || o_err_count !== '0) begin n_err++; $display("FAIL lock_counting: got %0d/%0d want 50/0", o_bit_count, o_err_count); end
        n_cmp++; if (o_is_zero !== 1'b1) begin n_err++; $display("FAIL lock_is_zero: got %b want 1", o_is_zero); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < OS && tcnt != 2; i++) step();
        i_clear = 1'b1;
        step();
        n_cmp++; if (o_bit_count !== '0 || o_err_count !== '0 || o_locked !== 1'b1) begin n_err++; $display("FAIL clear_on_decision: got %0d/%0d locked=%b want 0/0 locked=1", o_bit_count, o_err_count, o_locked); end
        run_cycles(OS);
        n_cmp++; if (o_bit_count !== CNT_W'(1)) begin n_err++; $display("FAIL clear_resume: got %0d want 1", o_bit_count); end
    endtask

    task automatic test_enable_freeze();
        logic             s_lk, s_z;
        logic [LW-1:0]    s_lat;
        logic [CNT_W-1:0] s_b, s_e;
        s_lk = o_locked; s_z = o_is_zero; s_lat = o_latency; s_b = o_bit_count; s_e = o_err_count;
        i_enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_cmp++;
            if (o_locked !== s_lk || o_is_zero !== s_z || o_latency !== s_lat || o_bit_count !== s_b || o_err_count !== s_e) begin
                n_err++; $display("FAIL freeze_cycle%0d: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", i, o_locked, o_latency, o_bit_count, o_err_count, s_lk, s_lat, s_b, s_e);
            end
        end
        i_enable = 1'b1;
        run_cycles(2 * OS);
        n_cmp++; if (o_bit_count !== CNT_W'(m_bits)) begin n_err++; $display("FAIL freeze_resume: got %0d want %0d", o_bit_count, m_bits); end
    endtask

    task automatic test_error_injection();
        int base;
        for (int i = 0; i < OS && tcnt != 0; i++) step();
        base = baud;
        fb0 = base + $urandom_range(0, 332);
        fb1 = base + $urandom_range(333, 665);
        fb2 = base + $urandom_range(666, 999);
        i_clear = 1'b1;
        run_cycles(1000 * OS);
        n_cmp++; if (o_err_count !== CNT_W'(3) || o_bit_count !== CNT_W'(1000)) begin n_err++; $display("FAIL inject_counts: got %0d/%0d want 3/1000", o_err_count, o_bit_count); end
        n_cmp++; if (o_locked !== 1'b1 || o_is_zero !== 1'b0) begin n_err++; $display("FAIL inject_flags: got locked=%b is_zero=%b want 1/0", o_locked, o_is_zero); end
        fb0 = -1; fb1 = -1; fb2 = -1;
    endtask

    task automatic test_loss();
        for (int i = 0; i < 4 * WINDOW * OS && (ndec % WINDOW) != 0; i++) step();
        inv = 1;
        loss_at = ndec + WINDOW;
        run_dec(loss_at - 1);
        n_cmp++; if (o_locked !== 1'b1) begin n_err++; $display("FAIL loss_early: got %b want 1", o_locked); end
        run_dec(loss_at);
        n_cmp++; if (o_locked !== 1'b0 || o_latency !== '0) begin n_err++; $display("FAIL loss_fall: got locked=%b lat=%0d want 0/0", o_locked, o_latency); end
        n_cmp++; if (o_bit_count !== CNT_W'(SATV) || o_err_count !== CNT_W'(514)) begin n_err++; $display("FAIL loss_counts: got %0d/%0d want %0d/514", o_bit_count, o_err_count, SATV); end
        inv = 0;
    endtask

    task automatic test_relock();
        lock_pol = 0;
        lock_at  = ndec + 6 * WINDOW;
        run_cycles(40);
        n_cmp++; if (o_bit_count !== CNT_W'(SATV) || o_err_count !== CNT_W'(514)) begin n_err++; $display("FAIL relock_hold: got %0d/%0d want %0d/514", o_bit_count, o_err_count, SATV); end
        run_dec(lock_at);
        n_cmp++; if (o_locked !== 1'b1 || o_latency !== LW'(5)) begin n_err++; $display("FAIL relock: got locked=%b lat=%0d want 1/5", o_locked, o_latency); end
        n_cmp++; if (o_bit_count !== '0 || o_err_count !== '0) begin n_err++; $display("FAIL relock_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count); end
    endtask

    task automatic test_reset_midlock();
        run_cycles(40);
        i_enable = 1'b0; i_clear = 1'b1;
        do_reset();
        i_enable = 1'b1;
        n_cmp++; if (o_locked !== 1'b0 || o_latency !== '0 || o_is_zero !== 1'b0) begin n_err++; $display("FAIL midlock_reset_flags: got %b/%0d/%b want 0/0/0", o_locked, o_latency, o_is_zero); end
        n_cmp++; if (o_bit_count !== '0 || o_err_count !== '0) begin n_err++; $display("FAIL midlock_reset_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count); end
    endtask

    task automatic test_polarity();
        dly = 3; inv = 1;
`ifdef BER_POLARITY_AUTO_EN
        lock_pol = 1;
        lock_at  = 4 * WINDOW;
        run_dec(lock_at);
        n_cmp++; if (o_locked !== 1'b1 || o_latency !== LW'(3)) begin n_err++; $display("FAIL polarity_lock: got locked=%b lat=%0d want 1/3", o_locked, o_latency); end
        run_cycles(200);
        n_cmp++; if (o_err_count !== '0 || o_bit_count !== CNT_W'(m_bits)) begin n_err++; $display("FAIL polarity_counts: got %0d/%0d want 0/%0d", o_err_count, o_bit_count, m_bits); end
`else
        run_dec(4 * WINDOW);
        n_cmp++; if (o_locked !== 1'b0 || o_latency !== LW'(4)) begin n_err++; $display("FAIL polarity_nolock: got locked=%b lat=%0d want 0/4", o_locked, o_latency); end
`endif
        inv = 0;
        do_reset();
    endtask

    task automatic test_wrap();
        dly = 20;
        for (int k = 1; k <= MAX_DLY + 1; k++) begin
            run_dec(k * WINDOW);
            n_cmp++;
            if (o_latency !== LW'(k % MAX_DLY) || o_locked !== 1'b0) begin
                n_err++; $display("FAIL wrap_window%0d: got lat=%0d locked=%b want %0d/0", k, o_latency, o_locked, k % MAX_DLY);
            end
        end
    endtask

    task automatic test_phase_change();
        run_cycles(10);
        i_phase = PW'(1);
        step();
        n_cmp++; if (o_latency !== '0 || o_locked !== 1'b0) begin n_err++; $display("FAIL phase_change: got lat=%0d locked=%b want 0/0", o_latency, o_locked); end
    endtask

    initial begin
        for (int i = 0; i < NREF; i++) refs[i] = 1'($urandom_range(1, 0));
        tcnt = 0; baud = 100; ndec = 0; dly = 5; lock_at = -1; loss_at = -1;
        fb0 = -1; fb1 = -1; fb2 = -1; inv = 0; lock_pol = 0; m_locked = 0; m_pol = 0;
        m_bits = 0; m_errs = 0; prev_phase = '0;
        i_reset = 1'b0; i_enable = 1'b1; i_clear = 1'b0; i_ref_bit = 1'b0; i_rx_bit = 1'b0; i_phase = PW'(2);
        test_reset();
        test_lock();
        test_clear();
        test_enable_freeze();
        test_error_injection();
        test_loss();
        test_relock();
        test_reset_midlock();
        test_polarity();
        test_wrap();
        test_phase_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
